// File: rtl/signed_sat_narrow_pipe.sv
// Two-stage signed narrowing pipe: optional rounded arithmetic shift, then clip to OUT_W.
// Flags clipped samples and counts delivered clipped beats in a sticky counter.
module signed_sat_narrow_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0,
    parameter int ROUND_EN = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND =
        (ROUND_EN != 0 && SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic signed [IN_W:0] SAT_MAX =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                     en;
    logic                     accept;
    logic signed [IN_W:0]     wide;
    logic                     s1_valid_d, s1_valid_q;
    logic signed [IN_W:0]     s1_val_d, s1_val_q;
    logic                     out_valid_d, out_valid_q;
    logic [OUT_W-1:0]         out_data_d, out_data_q;
    logic                     out_sat_d, out_sat_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;

    // Both stages move together; an empty output register never blocks stage 1.
    always_comb begin
        en       = ~out_valid_q | out_ready;
        accept   = in_valid & en;
        // One guard bit so adding the rounding constant cannot wrap at +max.
        wide     = $signed({in_data[IN_W-1], in_data}) + RND;

        s1_valid_d = s1_valid_q;
        s1_val_d   = s1_val_q;
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_val_d = wide >>> SHIFT;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_val_q > SAT_MAX) begin
                    out_data_d = {1'b0, {(OUT_W - 1){1'b1}}};
                    out_sat_d  = 1'b1;
                end else if (s1_val_q < SAT_MIN) begin
                    out_data_d = {1'b1, {(OUT_W - 1){1'b0}}};
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = s1_val_q[OUT_W-1:0];
                    out_sat_d  = 1'b0;
                end
            end
        end
    end

    // Counted on the handshake, so a stalled clipped beat is counted once.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_val_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_val_q    <= s1_val_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = cnt_q;

endmodule

// File: tb/tb_signed_sat_narrow_pipe.sv
// Bench for signed_sat_narrow_pipe: four configurations side by side, directed steps
// plus a random phase, scored against an arithmetic reference and a sticky-counter model.
module tb_signed_sat_narrow_pipe;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]       iv, ordy, clr;
    logic [N-1:0][15:0] idat;
    logic [N-1:0]       ird, ov, osat;
    logic [N-1:0][7:0]  odat;
    logic [2:0][15:0]   scnt;
    logic [1:0]         scnt3;

    always #5 clk = ~clk;

    // 0: defaults, 1: SHIFT=4 rounded, 2: SHIFT=4 truncated, 3: CNT_W=2
    signed_sat_narrow_pipe u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]), .out_sat(osat[0]),
        .clr_count(clr[0]), .sat_count(scnt[0]));
    signed_sat_narrow_pipe #(.SHIFT(4), .ROUND_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]), .out_sat(osat[1]),
        .clr_count(clr[1]), .sat_count(scnt[1]));
    signed_sat_narrow_pipe #(.SHIFT(4), .ROUND_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(odat[2]), .out_sat(osat[2]),
        .clr_count(clr[2]), .sat_count(scnt[2]));
    signed_sat_narrow_pipe #(.CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ird[3]), .in_data(idat[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(odat[3]), .out_sat(osat[3]),
        .clr_count(clr[3]), .sat_count(scnt3));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         sh   [N];
    bit         rn   [N];
    longint     cmax [N];
    longint     cntm [N];
    logic [8:0] expm [N][64];
    int         wp   [N];
    int         rp   [N];
    bit         acc_last   [N];
    bit         prev_stall [N];
    logic [8:0] prev_out   [N];
    logic [8:0] last_del   [N];
    int         ndel       [N];
    int         first_acc  [N];
    int         first_ov   [N];
    int         last_ov    [N];

    function automatic logic [8:0] ref_out(input logic [15:0] d, input int s, input bit r);
        longint v;
        v = longint'($signed(d));
        if (r && s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 127) return 9'h17F;
        if (v < -128) return 9'h180;
        return {1'b0, v[7:0]};
    endfunction

    function automatic longint cnt_of(input int k);
        if (k == 3) return longint'(scnt3);
        return longint'(scnt[k]);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_trackers(input int k);
        ndel[k] = 0; first_acc[k] = -1; first_ov[k] = -1; last_ov[k] = -1;
    endtask

    // One clock: score pre-edge handshakes, advance models, then check the counter.
    task automatic step();
        logic [8:0] e;
        #1;
        for (int k = 0; k < N; k++) begin
            acc_last[k] = iv[k] & ird[k];
            if (prev_stall[k]) begin
                chk("stall_hold_valid", ov[k], 1);
                chk("stall_hold_data", {osat[k], odat[k]}, prev_out[k]);
            end
            prev_stall[k] = ov[k] & ~ordy[k];
            prev_out[k]   = {osat[k], odat[k]};
            if (prev_stall[k]) chk("stall_in_ready", ird[k], 0);
            e = 9'h000;
            if (ov[k] && ordy[k]) begin
                if (rp[k] == wp[k]) begin
                    chk("spurious_out", ov[k], 0);
                end else begin
                    e = expm[k][rp[k] % 64];
                    chk("out_beat", {osat[k], odat[k]}, e);
                    rp[k]++;
                    last_del[k] = {osat[k], odat[k]};
                    ndel[k]++;
                    if (first_ov[k] < 0) first_ov[k] = cyc;
                    last_ov[k] = cyc;
                end
            end
            if (clr[k]) cntm[k] = 0;
            else if (e[8] && cntm[k] < cmax[k]) cntm[k]++;
            if (acc_last[k]) begin
                expm[k][wp[k] % 64] = ref_out(idat[k], sh[k], rn[k]);
                wp[k]++;
                if (first_acc[k] < 0) first_acc[k] = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) chk("sat_count", cnt_of(k), cntm[k]);
    endtask

    task automatic send(input int k, input logic [15:0] d);
        bit done;
        done = 0;
        iv[k] = 1'b1;
        idat[k] = d;
        for (int t = 0; t < 20 && !done; t++) begin
            step();
            done = acc_last[k];
        end
        if (!done) chk("send_timeout", 0, 1);
        iv[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int n);
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        repeat (n) step();
    endtask

    task automatic wait_ov(input int k);
        for (int t = 0; t < 8 && !ov[k]; t++) step();
        chk("wait_ov", ov[k], 1);
    endtask

    logic [15:0] clip_in  [6] = '{16'h0070, 16'h2000, 16'h9000, 16'hFF80, 16'h0080, 16'h007F};
    logic [8:0]  clip_exp [6] = '{9'h070, 9'h17F, 9'h180, 9'h080, 9'h17F, 9'h07F};
    logic [15:0] rnd_in   [4] = '{16'h0018, 16'hFFE8, 16'h07F8, 16'h8000};
    logic [8:0]  rnd_exp  [4] = '{9'h002, 9'h0FF, 9'h17F, 9'h180};
    logic [15:0] bp_in    [5] = '{16'h0011, 16'hF000, 16'h0022, 16'h0100, 16'hFFC3};

    initial begin
        int idx;
        sh   = '{0, 4, 4, 0};
        rn   = '{0, 1, 0, 0};
        cmax = '{65535, 65535, 65535, 3};
        for (int k = 0; k < N; k++) begin
            cntm[k] = 0; wp[k] = 0; rp[k] = 0; prev_stall[k] = 0;
            last_del[k] = '0; clr_trackers(k);
        end
        rst_n = 1'b0; iv = '0; ordy = '1; clr = '0; idat = '0;
        #2;
        for (int k = 0; k < N; k++) begin
            chk("rst_out_valid", ov[k], 0);
            chk("rst_out_data", odat[k], 0);
            chk("rst_out_sat", osat[k], 0);
            chk("rst_sat_count", cnt_of(k), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", ird[0], 1);

        // clip table on the default instance
        for (int i = 0; i < 6; i++) begin
            send(0, clip_in[i]);
            drain(0, 2);
            chk("clip", last_del[0], clip_exp[i]);
        end

        // latency and back-to-back throughput
        clr_trackers(0);
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idat[0] = 16'(i * 37 - 140);
            step();
            chk("b2b_accept", acc_last[0], 1);
        end
        drain(0, 3);
        chk("latency", first_ov[0] - first_acc[0], 2);
        chk("burst_span", last_ov[0] - first_ov[0], 7);
        chk("burst_count", ndel[0], 8);

        // backpressure mid-stream
        clr_trackers(0);
        idx = 0;
        for (int c = 0; c < 30 && (idx < 5 || rp[0] != wp[0]); c++) begin
            ordy[0] = !(c >= 3 && c < 6);
            iv[0] = (idx < 5);
            idat[0] = bp_in[idx < 5 ? idx : 4];
            step();
            if (acc_last[0]) idx++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        chk("bp_count", ndel[0], 5);

        // shift / round configurations
        for (int i = 0; i < 4; i++) begin
            send(1, rnd_in[i]);
            drain(1, 2);
            chk("round", last_del[1], rnd_exp[i]);
        end
        send(2, 16'h0018);
        drain(2, 2);
        chk("trunc", last_del[2], 9'h001);

        // counter behaviour
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("cnt_clr0", scnt[0], 0);
        repeat (3) send(0, 16'h9000);
        drain(0, 3);
        chk("cnt3", scnt[0], 3);
        ordy[0] = 1'b0;
        send(0, 16'h9000);
        wait_ov(0);
        repeat (4) step();
        drain(0, 2);
        chk("cnt_stall_once", scnt[0], 4);
        ordy[0] = 1'b0;
        send(0, 16'h9000);
        wait_ov(0);
        clr[0] = 1'b1; ordy[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("cnt_clr_wins", scnt[0], 0);
        chk("cnt_clr_beat", last_del[0], 9'h180);
        clr[3] = 1'b1; step(); clr[3] = 1'b0;
        repeat (5) send(3, 16'h9000);
        drain(3, 3);
        chk("cnt_sticky_w2", scnt3, 3);

        // random traffic on all configurations
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                iv[k]   = ($urandom % 4) != 0;
                ordy[k] = ($urandom % 4) != 0;
                clr[k]  = ($urandom % 24) == 0;
                if ($urandom % 3 == 0) idat[k] = 16'($urandom);
                else idat[k] = 16'($signed($urandom_range(0, 4095)) - 2048);
            end
            step();
        end
        iv = '0; clr = '0; ordy = '1;
        repeat (4) step();
        for (int k = 0; k < N; k++) chk("rand_drained", rp[k], wp[k]);

        // reset with output valid and stage 1 full
        ordy[0] = 1'b0;
        send(0, 16'h9000);
        send(0, 16'h0033);
        chk("pre_rst_valid", ov[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov[0], 0);
        chk("mid_rst_data", odat[0], 0);
        chk("mid_rst_sat", osat[0], 0);
        chk("mid_rst_count", scnt[0], 0);
        for (int k = 0; k < N; k++) begin
            rp[k] = wp[k]; cntm[k] = 0; prev_stall[k] = 0;
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clr_trackers(0);
        ordy[0] = 1'b1;
        send(0, 16'h0012);
        drain(0, 4);
        chk("post_rst_count", ndel[0], 1);
        chk("post_rst_data", last_del[0], 9'h012);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
